// File: rtl/scaler_issue_pkg.sv
// Shared widths, state encoding and helpers for the scaler operand issue stage.
package scaler_issue_pkg;

  localparam int ADD_OUT_WIDTH = 16;
  localparam int SCALER_WIDTH  = 16;
  localparam int NUM_CH        = 16;
  localparam int CH_W          = 4;
  localparam int PIX_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/scaler_table.sv
// Per-channel scaler coefficient store: one synchronous write port, one async read port.
// Contents survive reset; no read latency, write visible on the following cycle.
module scaler_table #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scaler_issue.sv
// Registers multiplier operands from the acc stream and delays valid/last/channel tags 2 cycles.
// Accepts one acc per cycle in RUN only; no downstream backpressure (multiplier has no enable).
module scaler_issue
  import scaler_issue_pkg::*;
#(
  parameter int ADD_OUT_WIDTH = scaler_issue_pkg::ADD_OUT_WIDTH,
  parameter int SCALER_WIDTH  = scaler_issue_pkg::SCALER_WIDTH,
  parameter int NUM_CH        = scaler_issue_pkg::NUM_CH,
  parameter int CH_W          = scaler_issue_pkg::CH_W,
  parameter int PIX_W         = scaler_issue_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_addr,
  input  logic [SCALER_WIDTH-1:0]  cfg_data,
  input  logic                     start,
  input  logic [CH_W:0]            ch_count,
  input  logic [PIX_W-1:0]         num_pix,
  input  logic                     acc_valid,
  input  logic [ADD_OUT_WIDTH-1:0] acc_data,
  output logic                     acc_ready,
  output logic [ADD_OUT_WIDTH-1:0] mult_in1,
  output logic [SCALER_WIDTH-1:0]  mult_in2,
  output logic                     res_valid,
  output logic                     res_last,
  output logic [CH_W-1:0]          res_ch,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef struct packed {
    logic            vld;
    logic            last;
    logic [CH_W-1:0] ch;
  } tag_t;

  localparam logic [CH_W:0]    CH_ONE  = (CH_W+1)'(1);
  localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);
  localparam logic [CH_W:0]    CH_MAX  = (CH_W+1)'(NUM_CH);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q;
  logic [PIX_W-1:0]  pix_q;
  logic [CH_W:0]     ch_count_q;
  logic [PIX_W-1:0]  num_pix_q;
  tag_t              tag1_q, tag2_q;
  logic              err_q;
  logic [SCALER_WIDTH-1:0] tbl_rd;

  logic hs, ch_wrap, is_last, start_ok, in_idle;

  assign in_idle  = (state_q == ST_IDLE);
  assign hs       = acc_valid && acc_ready;
  assign ch_wrap  = ({1'b0, ch_q} == (ch_count_q - CH_ONE));
  assign is_last  = ch_wrap && (pix_q == (num_pix_q - PIX_ONE));
  assign start_ok = start && (ch_count != '0) && (ch_count <= CH_MAX) && (num_pix != '0);

  // Writes are only legal in IDLE, so the async read never sees a same-cycle write.
  scaler_table #(
    .W     (SCALER_WIDTH),
    .DEPTH (NUM_CH),
    .AW    (CH_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && in_idle),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (ch_q),
    .rdata (tbl_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (hs && is_last) state_d = ST_DRAIN;
      ST_DRAIN: if (tag2_q.vld && tag2_q.last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_ready = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      pix_q      <= '0;
      ch_count_q <= '0;
      num_pix_q  <= '0;
      mult_in1   <= '0;
      mult_in2   <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (in_idle && start_ok) begin
        ch_q       <= '0;
        pix_q      <= '0;
        ch_count_q <= ch_count;
        num_pix_q  <= num_pix;
      end else if (hs) begin
        if (ch_wrap) begin
          ch_q  <= '0;
          pix_q <= pix_q + PIX_ONE;
        end else begin
          ch_q  <= ch_q + CH_W'(1);
        end
      end
      if (hs) begin
        mult_in1 <= acc_data;
        mult_in2 <= tbl_rd;
      end
      tag1_q <= tag_t'{vld: hs, last: hs && is_last, ch: ch_q};
      tag2_q <= tag1_q;
      err_q  <= (cfg_we && !in_idle) || (start && !(in_idle && start_ok));
    end
  end

  assign res_valid = tag2_q.vld;
  assign res_last  = tag2_q.vld && tag2_q.last;
  assign res_ch    = tag2_q.ch;
  assign done      = tag2_q.vld && tag2_q.last;
  assign err       = err_q;

endmodule

// File: tb/tb_scaler_issue.sv
// Directed bench for scaler_issue: table load, streaming, gaps, illegal start, cfg in RUN, reset mid-layer.
module tb_scaler_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        start;
  logic [4:0]  ch_count;
  logic [15:0] num_pix;
  logic        acc_valid;
  logic [15:0] acc_data;
  logic        acc_ready;
  logic [15:0] mult_in1;
  logic [15:0] mult_in2;
  logic        res_valid;
  logic        res_last;
  logic [3:0]  res_ch;
  logic        busy;
  logic        done;
  logic        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  scaler_issue dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .ch_count  (ch_count),
    .num_pix   (num_pix),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_ready (acc_ready),
    .mult_in1  (mult_in1),
    .mult_in2  (mult_in2),
    .res_valid (res_valid),
    .res_last  (res_last),
    .res_ch    (res_ch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input logic v, input logic l, input logic [3:0] c);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".res_last"},  32'(res_last),  32'(l));
    chk({tag, ".done"},      32'(done),      32'(l));
    if (v) chk({tag, ".res_ch"}, 32'(res_ch), 32'(c));
  endtask

  logic [15:0] tbl_exp [4];

  initial begin
    tbl_exp[0] = 16'h0002;
    tbl_exp[1] = 16'hFFFF;
    tbl_exp[2] = 16'h0003;
    tbl_exp[3] = 16'h0100;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    ch_count = '0; num_pix = '0; acc_valid = 1'b0; acc_data = '0;
    tick(); tick();

    // Reset state
    chk("rst.acc_ready", 32'(acc_ready), 0);
    chk("rst.busy",      32'(busy), 0);
    chk("rst.mult_in1",  32'(mult_in1), 0);
    chk("rst.mult_in2",  32'(mult_in2), 0);
    chk("rst.err",       32'(err), 0);
    chk_res("rst", 1'b0, 1'b0, 4'd0);
    chk("rst.res_ch",    32'(res_ch), 0);
    rst = 1'b0;

    // Table load
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = tbl_exp[i];
      tick();
    end
    cfg_we = 1'b0;
    chk("load.err", 32'(err), 0);

    // Layer 1: 4 channels x 2 pixels, acc every cycle
    start = 1'b1; ch_count = 5'd4; num_pix = 16'd2;
    tick();
    start = 1'b0;
    chk("l1.busy", 32'(busy), 1);
    chk("l1.acc_ready", 32'(acc_ready), 1);
    acc_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      acc_data = 16'(10 + k);
      tick();
      chk($sformatf("l1.mult_in1[%0d]", k), 32'(mult_in1), 32'(10 + k));
      chk($sformatf("l1.mult_in2[%0d]", k), 32'(mult_in2), 32'(tbl_exp[k % 4]));
      chk($sformatf("l1.acc_ready[%0d]", k), 32'(acc_ready), (k == 7) ? 0 : 1);
      if (k == 0) chk_res("l1.res0", 1'b0, 1'b0, 4'd0);
      else        chk_res($sformatf("l1.res[%0d]", k - 1), 1'b1, 1'b0, 4'((k - 1) % 4));
    end
    acc_valid = 1'b0;
    tick();
    chk_res("l1.res[7]", 1'b1, 1'b1, 4'd3);
    chk("l1.drain_busy", 32'(busy), 1);
    tick();
    chk("l1.idle_busy", 32'(busy), 0);
    chk_res("l1.after", 1'b0, 1'b0, 4'd0);

    // Layer 2 back-to-back: 3 channels x 1 pixel, gapped acc_valid
    start = 1'b1; ch_count = 5'd3; num_pix = 16'd1;
    tick();
    start = 1'b0;
    chk("l2.busy", 32'(busy), 1);
    chk("l2.err", 32'(err), 0);
    acc_valid = 1'b1; acc_data = 16'd20; tick();
    chk("l2.g0.mult_in1", 32'(mult_in1), 20);
    chk("l2.g0.mult_in2", 32'(mult_in2), 32'h2);
    chk_res("l2.g0", 1'b0, 1'b0, 4'd0);
    acc_valid = 1'b0; acc_data = 16'd99; tick();
    chk("l2.g1.mult_in1_hold", 32'(mult_in1), 20);
    chk("l2.g1.mult_in2_hold", 32'(mult_in2), 32'h2);
    chk_res("l2.g1", 1'b1, 1'b0, 4'd0);
    acc_valid = 1'b1; acc_data = 16'd21; tick();
    chk("l2.g2.mult_in1", 32'(mult_in1), 21);
    chk("l2.g2.mult_in2", 32'(mult_in2), 32'hFFFF);
    chk_res("l2.g2", 1'b0, 1'b0, 4'd0);
    acc_valid = 1'b0; acc_data = 16'd98; tick();
    chk("l2.g3.mult_in1_hold", 32'(mult_in1), 21);
    chk_res("l2.g3", 1'b1, 1'b0, 4'd1);
    acc_valid = 1'b1; acc_data = 16'd22; tick();
    chk("l2.g4.mult_in1", 32'(mult_in1), 22);
    chk("l2.g4.mult_in2", 32'(mult_in2), 32'h3);
    chk("l2.g4.acc_ready", 32'(acc_ready), 0);
    chk_res("l2.g4", 1'b0, 1'b0, 4'd0);
    acc_valid = 1'b0; tick();
    chk_res("l2.g5", 1'b1, 1'b1, 4'd2);
    tick();
    chk("l2.idle_busy", 32'(busy), 0);

    // Illegal starts
    start = 1'b1; ch_count = 5'd0; num_pix = 16'd1; tick();
    start = 1'b0;
    chk("ill0.err", 32'(err), 1);
    chk("ill0.busy", 32'(busy), 0);
    chk("ill0.acc_ready", 32'(acc_ready), 0);
    tick();
    chk("ill0.err_clear", 32'(err), 0);
    start = 1'b1; ch_count = 5'd17; num_pix = 16'd1; tick();
    start = 1'b0;
    chk("ill17.err", 32'(err), 1);
    chk("ill17.busy", 32'(busy), 0);
    tick();
    start = 1'b1; ch_count = 5'd2; num_pix = 16'd0; tick();
    start = 1'b0;
    chk("illpix.err", 32'(err), 1);
    chk("illpix.busy", 32'(busy), 0);
    chk("illpix.acc_ready", 32'(acc_ready), 0);
    tick();

    // Config write during RUN is rejected
    start = 1'b1; ch_count = 5'd2; num_pix = 16'd2; tick();
    start = 1'b0;
    chk("cfg.busy", 32'(busy), 1);
    acc_valid = 1'b1; acc_data = 16'd30;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'h7777;
    tick();
    cfg_we = 1'b0;
    chk("cfg.err", 32'(err), 1);
    chk("cfg.mult_in2_0", 32'(mult_in2), 32'h2);
    for (int k = 1; k < 4; k++) begin
      acc_data = 16'(30 + k); tick();
      chk($sformatf("cfg.mult_in2_%0d", k), 32'(mult_in2), 32'(tbl_exp[k % 2]));
    end
    acc_valid = 1'b0;
    tick();
    chk_res("cfg.last", 1'b1, 1'b1, 4'd1);
    tick();
    chk("cfg.idle_busy", 32'(busy), 0);

    // Reset after 5 of 8 handshakes
    start = 1'b1; ch_count = 5'd4; num_pix = 16'd2; tick();
    start = 1'b0;
    acc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      acc_data = 16'(40 + k); tick();
    end
    chk("mid.mult_in1", 32'(mult_in1), 44);
    rst = 1'b1; tick();
    chk("mid.acc_ready", 32'(acc_ready), 0);
    chk("mid.busy", 32'(busy), 0);
    chk("mid.mult_in1_rst", 32'(mult_in1), 0);
    chk("mid.mult_in2_rst", 32'(mult_in2), 0);
    chk("mid.res_ch", 32'(res_ch), 0);
    chk("mid.err", 32'(err), 0);
    chk_res("mid.rst", 1'b0, 1'b0, 4'd0);
    rst = 1'b0; acc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid.no_res[%0d]", k), 32'(res_valid), 0);
    end

    // Layer after reset: table intact, entry 1 not overwritten
    start = 1'b1; ch_count = 5'd2; num_pix = 16'd1; tick();
    start = 1'b0;
    acc_valid = 1'b1; acc_data = 16'd50; tick();
    chk("post.mult_in2_0", 32'(mult_in2), 32'h2);
    acc_data = 16'd51; tick();
    chk("post.mult_in1_1", 32'(mult_in1), 51);
    chk("post.mult_in2_1", 32'(mult_in2), 32'hFFFF);
    chk_res("post.res0", 1'b1, 1'b0, 4'd0);
    acc_valid = 1'b0; tick();
    chk_res("post.res1", 1'b1, 1'b1, 4'd1);
    tick();
    chk("post.idle_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
